// File: rtl/apu_dma_pkg.sv
// Shared types and constants for the APU DMA sequencer.
// Holds the state encoding, the OAM put port, get/put parity values and the get-cycle arbiter.
package apu_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_OAM_GET,
    S_OAM_PUT,
    S_DMC_GET
  } dma_state_e;

  localparam logic [15:0] SPR_PORT_DEFAULT = 16'h2004;

  localparam logic PAR_GET = 1'b0;
  localparam logic PAR_PUT = 1'b1;

  // DMC always wins a get slot; the OAM read simply slides to the next get.
  function automatic dma_state_e pick_get(input logic dmc_pend, input logic oam_pend);
    if (dmc_pend) return S_DMC_GET;
    if (oam_pend) return S_OAM_GET;
    return S_IDLE;
  endfunction

endpackage

// File: rtl/dma_get_put_parity.sv
// Free-running get/put parity plus halt-cycle detection.
// Decides whether the cycle after the halt needs an extra alignment cycle.
module dma_get_put_parity
  import apu_dma_pkg::*;
(
  input  logic clk_i,
  input  logic res_i,
  input  logic halting_i,
  input  logic cpu_rnw_i,
  output logic halt_done_o,
  output logic need_align_o
);

  logic parity_q;

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      parity_q <= PAR_GET;
    end else begin
      parity_q <= ~parity_q;
    end
  end

  // The core only stops on a read, so a write cycle keeps the halt pending.
  assign halt_done_o  = halting_i & cpu_rnw_i;
  assign need_align_o = halt_done_o & (parity_q == PAR_GET);

endmodule

// File: rtl/dma_sequencer.sv
// APU DMA sequencer: OAM sprite DMA via $4014 and DMC sample fetch, with the core held off via RDY.
// All bus controls are registered and decoded from the next state.
module dma_sequencer
  import apu_dma_pkg::*;
#(
  parameter logic [15:0] SPR_PORT = SPR_PORT_DEFAULT,
  parameter int unsigned N_BYTES  = 256
) (
  input  logic        clk_i,
  input  logic        res_i,
  input  logic        w4014_i,
  input  logic [7:0]  db_in_i,
  input  logic        cpu_rnw_i,
  input  logic        dmc_req_i,
  input  logic [15:0] dmc_addr_i,
  output logic        rdy_o,
  output logic [15:0] addr_o,
  output logic        addr_oe_o,
  output logic        rnw_dma_o,
  output logic        spr_ppu_o,
  output logic        dmc_ack_o,
  output logic        oam_busy_o
);

  localparam logic [7:0] CNT_MASK = 8'(N_BYTES - 1);

  dma_state_e  state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        oam_pend_q, oam_pend_d;
  logic        dmc_pend_q, dmc_pend_d;
  logic        rdy_q, addr_oe_q, rnw_dma_q, spr_ppu_q, dmc_ack_q;
  logic [15:0] addr_q;
  logic        halt_done, need_align, oam_accept, last_put;

  dma_get_put_parity u_parity (
    .clk_i        (clk_i),
    .res_i        (res_i),
    .halting_i    (state_q == S_HALT),
    .cpu_rnw_i    (cpu_rnw_i),
    .halt_done_o  (halt_done),
    .need_align_o (need_align)
  );

  assign oam_accept = w4014_i & ~oam_pend_q;
  assign last_put   = (state_q == S_OAM_PUT) && (cnt_q == CNT_MASK);

  // Pending requests include this cycle's strobes so RDY drops the very next cycle.
  always_comb begin
    page_d     = page_q;
    cnt_d      = cnt_q;
    oam_pend_d = oam_pend_q;
    dmc_pend_d = dmc_pend_q | dmc_req_i;

    if (oam_accept) begin
      page_d     = db_in_i;
      cnt_d      = '0;
      oam_pend_d = 1'b1;
    end

    if (state_q == S_OAM_PUT) begin
      cnt_d = (cnt_q + 8'd1) & CNT_MASK;
      if (last_put) oam_pend_d = 1'b0;
    end

    state_d = state_q;
    case (state_q)
      S_IDLE:    if (oam_pend_d | dmc_pend_d) state_d = S_HALT;
      S_HALT:    if (halt_done) state_d = need_align ? S_ALIGN : pick_get(dmc_pend_d, oam_pend_d);
      S_ALIGN:   state_d = pick_get(dmc_pend_d, oam_pend_d);
      S_OAM_PUT: state_d = pick_get(dmc_pend_d, oam_pend_d);
      S_OAM_GET: state_d = S_OAM_PUT;
      S_DMC_GET: state_d = S_ALIGN;
      default:   state_d = S_IDLE;
    endcase

    if (state_d == S_DMC_GET) dmc_pend_d = 1'b0;
  end

  // ALIGN doubles as the dead put slot that follows a DMC fetch.
  always_ff @(posedge clk_i) begin
    if (res_i) begin
      state_q    <= S_IDLE;
      page_q     <= '0;
      cnt_q      <= '0;
      oam_pend_q <= 1'b0;
      dmc_pend_q <= 1'b0;
      rdy_q      <= 1'b1;
      addr_oe_q  <= 1'b0;
      addr_q     <= '0;
      rnw_dma_q  <= 1'b1;
      spr_ppu_q  <= 1'b0;
      dmc_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      cnt_q      <= cnt_d;
      oam_pend_q <= oam_pend_d;
      dmc_pend_q <= dmc_pend_d;
      rdy_q      <= (state_d == S_IDLE);
      addr_oe_q  <= (state_d inside {S_OAM_GET, S_OAM_PUT, S_DMC_GET});
      rnw_dma_q  <= (state_d != S_OAM_PUT);
      spr_ppu_q  <= (state_d == S_OAM_PUT);
      dmc_ack_q  <= (state_d == S_DMC_GET);
      case (state_d)
        S_OAM_GET: addr_q <= {page_d, cnt_d};
        S_OAM_PUT: addr_q <= SPR_PORT;
        S_DMC_GET: addr_q <= dmc_addr_i;
        default:   addr_q <= '0;
      endcase
    end
  end

  assign rdy_o      = rdy_q;
  assign addr_o     = addr_q;
  assign addr_oe_o  = addr_oe_q;
  assign rnw_dma_o  = rnw_dma_q;
  assign spr_ppu_o  = spr_ppu_q;
  assign dmc_ack_o  = dmc_ack_q;
  assign oam_busy_o = oam_pend_q;

endmodule

// File: tb/tb_dma_sequencer.sv
// Directed bench for dma_sequencer: expected bus transactions are queued when a request is driven
// and popped as the DMA drives the bus; stall length and first-cycle timing are checked per scenario.
module tb_dma_sequencer;

   typedef struct packed {
      logic [15:0] addr;
      logic        rnw;
      logic        spr;
      logic        ack;
   } busTxn_t;

   logic        clk = 1'b0;
   logic        res;
   logic        w4014;
   logic [7:0]  db;
   logic        cpuRnw;
   logic        dmcReq;
   logic [15:0] dmcAddr;
   logic        rdy, addrOe, rnwDma, sprPpu, dmcAck, oamBusy;
   logic [15:0] addr;

   busTxn_t expQ[$];
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int stallCnt, firstOeCyc, ackCyc, n;

   dma_sequencer dut (
      .clk_i      (clk),
      .res_i      (res),
      .w4014_i    (w4014),
      .db_in_i    (db),
      .cpu_rnw_i  (cpuRnw),
      .dmc_req_i  (dmcReq),
      .dmc_addr_i (dmcAddr),
      .rdy_o      (rdy),
      .addr_o     (addr),
      .addr_oe_o  (addrOe),
      .rnw_dma_o  (rnwDma),
      .spr_ppu_o  (sprPpu),
      .dmc_ack_o  (dmcAck),
      .oam_busy_o (oamBusy)
   );

   always #5 clk = ~clk;

   // Reference cycle index: cycle 0 follows the last reset edge, so its low bit is the get/put parity.
   always @(posedge clk) cyc <= res ? 0 : cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput(tag, {10'd0, rdy, addrOe, rnwDma, sprPpu, dmcAck, oamBusy, addr},
                  {10'd0, 6'b101000, 16'h0000});
   endtask

   // Per-cycle observation: stall count, first DMA/ack cycle, and scoreboard pop on bus-owned cycles.
   task automatic sampleCycle();
      busTxn_t obsTxn, expTxn;
      if (!rdy) stallCnt++;
      if (dmcAck && ackCyc < 0) ackCyc = cyc;
      if (addrOe) begin
         if (firstOeCyc < 0) firstOeCyc = cyc;
         obsTxn = '{addr, rnwDma, sprPpu, dmcAck};
         expTxn = (expQ.size() > 0) ? expQ.pop_front() : busTxn_t'(19'h7FFFF);
         checkOutput("bus_txn", {13'd0, obsTxn}, {13'd0, expTxn});
      end else begin
         checkOutput("idle_ctl", {30'd0, sprPpu, dmcAck}, 32'd0);
      end
   endtask

   task automatic applyStimulus(input logic w, input logic [7:0] d, input logic rnw, input logic req);
      sampleCycle();
      w4014  = w;
      db     = d;
      cpuRnw = rnw;
      dmcReq = req;
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   task automatic waitParity(input logic p);
      if (cyc[0] != p) idle(1);
   endtask

   task automatic startTest();
      stallCnt   = 0;
      firstOeCyc = -1;
      ackCyc     = -1;
      n          = cyc;
   endtask

   task automatic waitDone(input int limit, input string tag);
      logic done;
      done = 1'b0;
      for (int i = 0; i < limit && !done; i++) begin
         if (expQ.size() == 0 && rdy) done = 1'b1;
         else idle(1);
      end
      checkOutput(tag, {31'd0, done}, 32'd1);
   endtask

   task automatic pushDmc(input logic [15:0] a);
      expQ.push_back(busTxn_t'{a, 1'b1, 1'b0, 1'b1});
   endtask

   task automatic pushOam(input logic [7:0] page, input int dmcAt, input logic [15:0] a);
      for (int i = 0; i < 256; i++) begin
         if (i == dmcAt) pushDmc(a);
         expQ.push_back(busTxn_t'{{page, 8'(i)}, 1'b1, 1'b0, 1'b0});
         expQ.push_back(busTxn_t'{16'h2004, 1'b0, 1'b1, 1'b0});
      end
      if (dmcAt == 256) pushDmc(a);
   endtask

   initial begin
      res = 1'b1; w4014 = 1'b0; db = 8'h00; cpuRnw = 1'b1; dmcReq = 1'b0; dmcAddr = 16'h0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      checkResetState("reset_state");
      res = 1'b0;
      idle(2);

      $display("[TB] OAM DMA started on a get cycle");
      waitParity(1'b0);
      startTest();
      pushOam(8'h02, -1, 16'h0000);
      applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
      checkOutput("t1_rdy_low", {31'd0, rdy}, 32'd0);
      checkOutput("t1_busy", {31'd0, oamBusy}, 32'd1);
      idle(10);
      applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
      waitDone(700, "t1_done");
      checkOutput("t1_stall", stallCnt, 32'd513);
      checkOutput("t1_first_read", firstOeCyc - n, 32'd2);
      checkOutput("t1_busy_end", {31'd0, oamBusy}, 32'd0);

      $display("[TB] OAM DMA started on a put cycle");
      waitParity(1'b1);
      startTest();
      pushOam(8'h02, -1, 16'h0000);
      applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
      waitDone(700, "t2_done");
      checkOutput("t2_stall", stallCnt, 32'd514);
      checkOutput("t2_first_read", firstOeCyc - n, 32'd3);

      $display("[TB] halt held off by core writes");
      waitParity(1'b0);
      startTest();
      pushOam(8'h02, -1, 16'h0000);
      applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t3_halt_oe", {31'd0, addrOe}, 32'd0);
      waitDone(700, "t3_done");
      checkOutput("t3_stall", stallCnt, 32'd515);
      checkOutput("t3_first_read", firstOeCyc - n, 32'd4);

      $display("[TB] DMC fetch steals OAM byte 16 slot");
      waitParity(1'b0);
      startTest();
      dmcAddr = 16'hC000;
      pushOam(8'h02, 16, 16'hC000);
      applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
      idle(32);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
      waitDone(700, "t4_done");
      checkOutput("t4_stall", stallCnt, 32'd515);
      checkOutput("t4_ack_cycle", ackCyc - n, 32'd34);

      $display("[TB] standalone DMC, aligned and misaligned");
      waitParity(1'b0);
      startTest();
      dmcAddr = 16'hC040;
      pushDmc(16'hC040);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
      waitDone(20, "t5a_done");
      checkOutput("t5a_stall", stallCnt, 32'd3);
      checkOutput("t5a_ack_cycle", ackCyc - n, 32'd2);
      waitParity(1'b1);
      startTest();
      dmcAddr = 16'hC7FF;
      pushDmc(16'hC7FF);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
      waitDone(20, "t5b_done");
      checkOutput("t5b_stall", stallCnt, 32'd4);
      checkOutput("t5b_ack_cycle", ackCyc - n, 32'd3);

      $display("[TB] W4014 and DMC request in the same cycle");
      waitParity(1'b0);
      startTest();
      dmcAddr = 16'hC100;
      pushDmc(16'hC100);
      pushOam(8'h03, -1, 16'h0000);
      applyStimulus(1'b1, 8'h03, 1'b0, 1'b1);
      waitDone(700, "t7_done");
      checkOutput("t7_stall", stallCnt, 32'd515);
      checkOutput("t7_ack_cycle", ackCyc - n, 32'd2);

      $display("[TB] reset in the middle of a transfer");
      waitParity(1'b0);
      startTest();
      pushOam(8'h02, -1, 16'h0000);
      applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
      idle(129);
      checkOutput("t6_mid_addr", {16'd0, addr}, 32'h0000_0240);
      res = 1'b1;
      idle(1);
      expQ.delete();
      checkResetState("t6_reset_state");
      res = 1'b0;
      idle(1);

      $display("[TB] restart after reset with DMC request on the last put");
      waitParity(1'b0);
      startTest();
      dmcAddr = 16'hC200;
      pushOam(8'h05, 256, 16'hC200);
      applyStimulus(1'b1, 8'h05, 1'b0, 1'b0);
      idle(512);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
      waitDone(700, "t8_done");
      checkOutput("t8_stall", stallCnt, 32'd515);
      checkOutput("t8_ack_cycle", ackCyc - n, 32'd514);
      checkOutput("t8_busy_end", {31'd0, oamBusy}, 32'd0);

      idle(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
